mont_redc_serial: RTL and testbench
===================================

MONT_REDC_SERIAL -- requirements
Module: mont_redc_serial

Interface
REQ-001 Parameter WIDTH, default 512: modulus width in bits.
REQ-002 Parameter DIGIT, default 32: digit width processed per reduction step; WIDTH SHALL be an integer multiple of DIGIT, K = WIDTH/DIGIT.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 t_in  input  2*WIDTH  value to reduce; caller guarantees t_in < n_in*2^WIDTH.
REQ-006 n_in  input  WIDTH  odd modulus N.
REQ-007 n0inv_in  input  DIGIT  precomputed -N^-1 mod 2^DIGIT.
REQ-008 valid_in  input  1  request valid.
REQ-009 ready_out  output  1  block can accept a request.
REQ-010 x_out  output  WIDTH  result t*2^-WIDTH mod N, in [0, N).
REQ-011 valid_out  output  1  x_out valid.
REQ-012 ready_in  input  1  downstream accepts x_out.
REQ-013 busy_out  output  1  high from the cycle after acceptance until the result is accepted.

Function
REQ-014 A request SHALL be accepted on a rising edge where valid_in && ready_out; t_in, n_in, n0inv_in SHALL be registered at that edge and ignored afterwards.
REQ-015 ready_out SHALL equal (state == IDLE); valid_in while not ready SHALL be ignored.
REQ-016 States: IDLE, DIGIT_M, DIGIT_ACC, FINAL, OUT; IDLE->DIGIT_M on acceptance.
REQ-017 DIGIT_M: m <= (T[DIGIT-1:0] * n0inv) mod 2^DIGIT; next DIGIT_ACC.
REQ-018 DIGIT_ACC: T <= (T + m*N) >> DIGIT, exact with no truncation (T register at least 2*WIDTH+1 bits); digit counter increments; next DIGIT_M if counter < K, else FINAL.
REQ-019 FINAL: x_out <= (T >= N) ? T - N : T[WIDTH-1:0]; valid_out <= 1; next OUT.
REQ-020 OUT: x_out and valid_out held stable until valid_out && ready_in at a rising edge, then valid_out <= 0, state <= IDLE.
REQ-021 Latency: valid_out SHALL first be high 2K+1 rising edges after the acceptance edge; with ready_in held high, the next request SHALL be acceptable 2K+3 edges after the previous one.
REQ-022 An ignored request SHALL NOT alter any internal register.
REQ-023 Input t_in = 0 SHALL yield x_out = 0; t_in = N SHALL yield x_out = 0.

Reset
REQ-024 While rst_in is high at an edge: state <= IDLE, ready_out = 1, valid_out = 0, busy_out = 0, x_out = 0, T, m and digit counter = 0.
REQ-025 Reset during any state SHALL abandon the operation with no valid_out pulse.

Configuration
REQ-026 Macro MONT_REDC_SERIAL_ABORT_EN: when defined, input port abort_in (1 bit) SHALL exist; abort_in high at an edge in any non-IDLE state SHALL set state <= IDLE, valid_out <= 0, busy_out <= 0, x_out unchanged; abort_in in IDLE has no effect; abort_in SHALL have priority over acceptance and output handshake, rst_in over abort_in.
REQ-027 When MONT_REDC_SERIAL_ABORT_EN is undefined, abort_in SHALL NOT exist and all other behaviour is identical.

Structure
REQ-028 State enum type and a function computing K from WIDTH/DIGIT SHALL live in shared package mont_pkg.
REQ-029 The DIGIT x WIDTH multiply-accumulate SHALL be a sub-module mont_digit_mac (inputs T, m, N; output (T + m*N) >> DIGIT), combinational, reusable by future multiplier blocks.

Verification (WIDTH=16, DIGIT=8, N=0xF00D, n0inv=0x3B)
REQ-030 t_in=0x0001_0000 -> x_out=0x0001, valid_out high exactly 5 edges after acceptance.
REQ-031 t_in=0x0005_0000 -> x_out=0x0005; t_in=0xF00D -> x_out=0x0000; t_in=0 -> x_out=0.
REQ-032 1000 random t_in < N*2^16 vs reference model t*2^-16 mod N, back-to-back with ready_in=1 -> all match, acceptances every 7 edges.
REQ-033 ready_in held low 10 cycles at result -> x_out, valid_out stable; valid_in pulses meanwhile ignored (ready_out=0).
REQ-034 rst_in high in DIGIT_ACC of digit 1 -> next cycle ready_out=1, valid_out=0, busy_out=0; fresh request then reduces correctly.
REQ-035 With MONT_REDC_SERIAL_ABORT_EN, abort_in in DIGIT_M -> IDLE next cycle, no valid_out; abort_in simultaneous with ready_in in OUT -> no further handshake, IDLE.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared types and helpers for the Montgomery reduction blocks: FSM state encoding
// and the digit-count calculation.
package mont_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DIGIT_M,
      DIGIT_ACC,
      FINAL,
      OUT
   } state_t;

   // Number of DIGIT-wide reduction steps needed to cover a WIDTH-bit modulus.
   function automatic int k_digits(input int width, input int digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/mont_digit_mac.sv
// Combinational digit multiply-accumulate step: res = (t + m*n) >> DIGIT.
// Exact for any t below n*2^WIDTH; shared with future modular multiplier blocks.
module mont_digit_mac #(
   parameter int WIDTH = 512,
   parameter int DIGIT = 32
) (
   input  logic [2*WIDTH:0]   t,
   input  logic [DIGIT-1:0]   m,
   input  logic [WIDTH-1:0]   n,
   output logic [2*WIDTH:0]   res
);

   localparam int PW = DIGIT + WIDTH;
   localparam int SW = 2*WIDTH + 2;

   logic [PW-1:0] prod;
   logic [SW-1:0] sum;

   // Both operands are widened to the full product width so nothing is lost in the multiply.
   assign prod = {{DIGIT{1'b0}}, n} * {{WIDTH{1'b0}}, m};
   assign sum  = {1'b0, t} + {{(SW-PW){1'b0}}, prod};
   assign res  = (2*WIDTH+1)'(sum >> DIGIT);

endmodule

// File: rtl/mont_redc_serial.sv
// Digit-serial Montgomery reduction x = t * 2^-WIDTH mod N, one digit per two cycles.
// Optional abort input enabled by defining MONT_REDC_SERIAL_ABORT_EN.
module mont_redc_serial
   import mont_pkg::*;
#(
   parameter int WIDTH = 512,
   parameter int DIGIT = 32
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
`ifdef MONT_REDC_SERIAL_ABORT_EN
   input  logic                 abort_in,
`endif
   input  logic [2*WIDTH-1:0]   t_in,
   input  logic [WIDTH-1:0]     n_in,
   input  logic [DIGIT-1:0]     n0inv_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic [WIDTH-1:0]     x_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 busy_out
);

   localparam int K  = k_digits(WIDTH, DIGIT);
   localparam int TW = 2*WIDTH + 1;
   localparam int CW = $clog2(K + 1);

   state_t            state;
   logic [TW-1:0]     t_reg;
   logic [WIDTH-1:0]  n_reg;
   logic [DIGIT-1:0]  n0inv_reg;
   logic [DIGIT-1:0]  m_reg;
   logic [CW-1:0]     cnt;

   logic [TW-1:0]     mac_out;
   logic [DIGIT-1:0]  m_next;
   logic [CW-1:0]     cnt_inc;
   logic [TW-1:0]     n_ext;
   logic              abort_hit;

   mont_digit_mac #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) u_mac (
      .t   (t_reg),
      .m   (m_reg),
      .n   (n_reg),
      .res (mac_out)
   );

   // Product truncated to DIGIT bits is exactly the mod 2^DIGIT reduction.
   assign m_next  = t_reg[DIGIT-1:0] * n0inv_reg;
   assign cnt_inc = cnt + 1'b1;
   assign n_ext   = {{(WIDTH+1){1'b0}}, n_reg};

`ifdef MONT_REDC_SERIAL_ABORT_EN
   assign abort_hit = abort_in && (state != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign ready_out = (state == IDLE);
   assign busy_out  = (state != IDLE);

   // NOTE: every register below is updated with <= so all reads see pre-edge values;
   // a blocking = here would let later statements see half-updated state.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= IDLE;
         t_reg     <= '0;
         n_reg     <= '0;
         n0inv_reg <= '0;
         m_reg     <= '0;
         cnt       <= '0;
         x_out     <= '0;
         valid_out <= 1'b0;
      end else if (abort_hit) begin
         state     <= IDLE;
         valid_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_in) begin
                  t_reg     <= {1'b0, t_in};
                  n_reg     <= n_in;
                  n0inv_reg <= n0inv_in;
                  cnt       <= '0;
                  state     <= DIGIT_M;
               end
            end
            DIGIT_M: begin
               m_reg <= m_next;
               state <= DIGIT_ACC;
            end
            DIGIT_ACC: begin
               t_reg <= mac_out;
               cnt   <= cnt_inc;
               state <= (cnt_inc < CW'(K)) ? DIGIT_M : FINAL;
            end
            FINAL: begin
               // After K steps t_reg < 2N, so one conditional subtract lands in [0, N).
               if (t_reg >= n_ext) x_out <= WIDTH'(t_reg - n_ext);
               else                x_out <= t_reg[WIDTH-1:0];
               valid_out <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (ready_in) begin
                  valid_out <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_redc_serial.sv
// Self-checking bench for mont_redc_serial at WIDTH=16, DIGIT=8, N=0xF00D.
// Abort scenarios run only when MONT_REDC_SERIAL_ABORT_EN is defined.
module tb_mont_redc_serial;

   localparam int          WIDTH = 16;
   localparam int          DIGIT = 8;
   localparam logic [15:0] N     = 16'hF00D;
   localparam logic [7:0]  N0INV = 8'h3B;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] t_in;
   logic [15:0] n_in;
   logic [7:0]  n0inv_in;
   logic        valid_in;
   logic        ready_out;
   logic [15:0] x_out;
   logic        valid_out;
   logic        ready_in;
   logic        busy_out;
`ifdef MONT_REDC_SERIAL_ABORT_EN
   logic        abort_in;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   longint unsigned r_inv;

   mont_redc_serial #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
`ifdef MONT_REDC_SERIAL_ABORT_EN
      .abort_in  (abort_in),
`endif
      .t_in      (t_in),
      .n_in      (n_in),
      .n0inv_in  (n0inv_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .x_out     (x_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .busy_out  (busy_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: x = (t mod N) * R^-1 mod N, with R^-1 found by search at start-up.
   function automatic logic [15:0] model(input logic [31:0] t);
      longint unsigned tm;
      tm = 64'(t) % 64'(N);
      return 16'((tm * r_inv) % 64'(N));
   endfunction

   function automatic logic [31:0] rand_t();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return 32'(r % (64'(N) << 16));
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_ready();
      int c = 0;
      while (!ready_out && c < 100) begin
         step();
         c++;
      end
      check("ready_wait", 64'(ready_out), 64'd1);
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      while (!valid_out && edges < 100) begin
         step();
         edges++;
      end
      check("valid_wait", 64'(valid_out), 64'd1);
   endtask

   // Presents one request, then scrambles the inputs to confirm they were captured.
   task automatic accept(input logic [31:0] t);
      wait_ready();
      t_in     = t;
      n_in     = N;
      n0inv_in = N0INV;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      t_in     = 32'hDEAD_BEEF;
      n_in     = 16'h1235;
      n0inv_in = 8'h77;
      check("busy_after_accept", 64'(busy_out), 64'd1);
   endtask

   task automatic run_one(input string tag, input logic [31:0] t, input logic [15:0] exp);
      int e;
      accept(t);
      wait_valid(e);
      check({tag, "_latency"}, 64'(e), 64'd5);
      check({tag, "_x"}, 64'(x_out), 64'(exp));
      step();
      check({tag, "_valid_drop"}, 64'(valid_out), 64'd0);
      check({tag, "_ready_back"}, 64'(ready_out), 64'd1);
   endtask

   initial begin
      logic [15:0] exp_q[$];
      logic [31:0] cur_t;
      logic        acc;
      int          e, edge_n, last_acc, n_acc, n_done, seen;

      for (int r = 0; r < int'(N); r++)
         if ((64'(r) * 64'd65536) % 64'(N) == 64'd1) r_inv = 64'(r);

      rst_in   = 1'b1;
      valid_in = 1'b0;
      ready_in = 1'b1;
      t_in     = '0;
      n_in     = N;
      n0inv_in = N0INV;
`ifdef MONT_REDC_SERIAL_ABORT_EN
      abort_in = 1'b0;
`endif
      repeat (3) step();
      check("rst_ready", 64'(ready_out), 64'd1);
      check("rst_valid", 64'(valid_out), 64'd0);
      check("rst_busy",  64'(busy_out),  64'd0);
      check("rst_x",     64'(x_out),     64'd0);
      rst_in = 1'b0;
      step();
      check("idle_ready", 64'(ready_out), 64'd1);

      // Directed vectors with hand-derived results (R = 2^16).
      run_one("t_r",    32'h0001_0000, 16'h0001);
      run_one("t_5r",   32'h0005_0000, 16'h0005);
      run_one("t_eq_n", 32'h0000_F00D, 16'h0000);
      run_one("t_zero", 32'h0000_0000, 16'h0000);
      run_one("t_2r",   32'h0002_0000, 16'h0002);
      run_one("t_max",  {N, 16'h0000} - 32'd1, model({N, 16'h0000} - 32'd1));

      // Back-to-back random stream with ready_in high.
      ready_in = 1'b1;
      n_in     = N;
      n0inv_in = N0INV;
      cur_t    = rand_t();
      t_in     = cur_t;
      valid_in = 1'b1;
      edge_n   = 0;
      last_acc = 0;
      n_acc    = 0;
      n_done   = 0;
      while (n_done < 1000 && edge_n < 20000) begin
         if (valid_out) begin
            if (exp_q.size() > 0) check("rand_x", 64'(x_out), 64'(exp_q.pop_front()));
            else check("rand_queue", 64'(exp_q.size()), 64'd1);
            n_done++;
         end
         acc = valid_in && ready_out;
         step();
         edge_n++;
         if (acc) begin
            exp_q.push_back(model(cur_t));
            if (n_acc > 0) check("b2b_gap", 64'(edge_n - last_acc), 64'd7);
            last_acc = edge_n;
            n_acc++;
            if (n_acc < 1000) begin
               cur_t = rand_t();
               t_in  = cur_t;
            end else begin
               valid_in = 1'b0;
            end
         end
      end
      valid_in = 1'b0;
      check("rand_done", 64'(n_done), 64'd1000);

      // Output stall: result must hold while requests are ignored.
      ready_in = 1'b0;
      accept(32'h0005_0000);
      wait_valid(e);
      check("stall_latency", 64'(e), 64'd5);
      for (int i = 0; i < 10; i++) begin
         check("stall_x",     64'(x_out),     64'd5);
         check("stall_valid", 64'(valid_out), 64'd1);
         check("stall_ready", 64'(ready_out), 64'd0);
         valid_in = 1'b1;
         t_in     = (i % 2 == 1) ? 32'h0001_0000 : 32'h0003_0000;
         step();
      end
      valid_in = 1'b0;
      check("stall_x_end", 64'(x_out), 64'd5);
      ready_in = 1'b1;
      step();
      check("stall_release_valid", 64'(valid_out), 64'd0);
      check("stall_release_ready", 64'(ready_out), 64'd1);
      run_one("after_stall", 32'h0003_0000, 16'h0003);

      // Reset while in DIGIT_ACC of the first digit.
      accept(32'h0001_0000);
      step();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      check("midrst_ready", 64'(ready_out), 64'd1);
      check("midrst_valid", 64'(valid_out), 64'd0);
      check("midrst_busy",  64'(busy_out),  64'd0);
      check("midrst_x",     64'(x_out),     64'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (valid_out) seen++;
         step();
      end
      check("midrst_no_valid", 64'(seen), 64'd0);
      run_one("post_rst", 32'h0005_0000, 16'h0005);

`ifdef MONT_REDC_SERIAL_ABORT_EN
      // Abort in DIGIT_M.
      accept(32'h0002_0000);
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      check("abort_m_ready", 64'(ready_out), 64'd1);
      check("abort_m_busy",  64'(busy_out),  64'd0);
      check("abort_m_valid", 64'(valid_out), 64'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (valid_out) seen++;
         step();
      end
      check("abort_m_no_valid", 64'(seen), 64'd0);

      // Abort together with ready_in in OUT.
      ready_in = 1'b0;
      accept(32'h0004_0000);
      wait_valid(e);
      check("abort_out_x_before", 64'(x_out), 64'd4);
      abort_in = 1'b1;
      ready_in = 1'b1;
      step();
      abort_in = 1'b0;
      check("abort_out_valid", 64'(valid_out), 64'd0);
      check("abort_out_ready", 64'(ready_out), 64'd1);
      check("abort_out_x_held", 64'(x_out), 64'd4);
      run_one("post_abort", 32'h0001_0000, 16'h0001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
